// File: rtl/bm_param_memory_clear.sv
// ---------------------------------------------------------------------------
// bm_param_memory_clear : simple-dual-port RAM with a post-reset clear sweep,
// write-first read bypass; optional 2nd output stage via BM_MEM_OUTREG_EN.
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module bm_param_memory_clear #(
  parameter int                    DATA_WIDTH  = 8,
  parameter int                    ADDR_WIDTH  = 2,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] address_in,
  input  logic [DATA_WIDTH-1:0] value_in,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] address_out,
  output logic [DATA_WIDTH-1:0] value_out,
  output logic                  valid_out,
  output logic                  busy
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   clear_ptr_q, clear_ptr_d;
  logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

  logic                    mem_we;
  logic [ADDR_WIDTH-1:0]   mem_waddr;
  logic [DATA_WIDTH-1:0]   mem_wdata;
  logic                    rd_en;
  logic [DATA_WIDTH-1:0]   rd_data_d;
  logic [DATA_WIDTH-1:0]   rd_data_q;
  logic                    rd_valid_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_CLEAR;
      clear_ptr_q <= '0;
    end else begin
      state_q     <= state_d;
      clear_ptr_q <= clear_ptr_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    clear_ptr_d = clear_ptr_q;
    mem_we      = 1'b0;
    mem_waddr   = address_in;
    mem_wdata   = value_in;
    rd_en       = 1'b0;
    busy        = 1'b0;
    case (state_q)
      ST_CLEAR: begin
        busy        = 1'b1;
        mem_we      = 1'b1;
        mem_waddr   = clear_ptr_q;
        mem_wdata   = CLEAR_VALUE;
        clear_ptr_d = clear_ptr_q + 1'b1;
        if (clear_ptr_q == '1) begin
          state_d = ST_READY;
        end
      end
      ST_READY: begin
        mem_we = we;
        rd_en  = re;
      end
      default: state_d = ST_CLEAR;
    endcase
  end

  // Write-first: a read hitting the word being written sees the new data.
  always_comb begin
    rd_data_d = mem_q[address_out];
    if (mem_we && (mem_waddr == address_out)) begin
      rd_data_d = mem_wdata;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset && mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= rd_en;
      if (rd_en) begin
        rd_data_q <= rd_data_d;
      end
    end
  end

`ifdef BM_MEM_OUTREG_EN
  logic [DATA_WIDTH-1:0] out_data_q;
  logic                  out_valid_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_data_q  <= rd_data_q;
      out_valid_q <= rd_valid_q;
    end
  end

  assign value_out = out_data_q;
  assign valid_out = out_valid_q;
`else
  assign value_out = rd_data_q;
  assign valid_out = rd_valid_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_bm_param_memory_clear.sv
// ---------------------------------------------------------------------------
// tb_bm_param_memory_clear : directed + randomized checks against a
// behavioural memory model. Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_bm_param_memory_clear;

`ifdef BM_MEM_OUTREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif
  localparam int DEPTH = 4;

  logic       clock;
  logic       reset;
  logic       we;
  logic [1:0] address_in;
  logic [7:0] value_in;
  logic       re;
  logic [1:0] address_out;
  logic [7:0] value_out;
  logic       valid_out;
  logic       busy;

  bm_param_memory_clear #(
    .DATA_WIDTH (8),
    .ADDR_WIDTH (2),
    .CLEAR_VALUE(8'h00)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .we         (we),
    .address_in (address_in),
    .value_in   (value_in),
    .re         (re),
    .address_out(address_out),
    .value_out  (value_out),
    .valid_out  (valid_out),
    .busy       (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: memory contents, remaining sweep cycles, read pipeline.
  logic [7:0] m_mem [DEPTH];
  int         sweep_left = DEPTH;
  bit         pv [LAT];
  logic [7:0] pd [LAT];
  bit         exp_valid = 1'b0;
  logic [7:0] exp_val   = 8'h00;
  bit         exp_busy  = 1'b1;

  task automatic cyc(input bit rst, input bit w, input logic [1:0] wa,
                     input logic [7:0] wd, input bit r, input logic [1:0] ra);
    bit         rdy;
    logic [7:0] rdat;
    reset = rst; we = w; address_in = wa; value_in = wd; re = r; address_out = ra;
    @(posedge clock);
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) m_mem[i] = 8'h00;
      for (int i = 0; i < LAT; i++) begin pv[i] = 1'b0; pd[i] = 8'h00; end
      sweep_left = DEPTH;
      exp_val    = 8'h00;
    end else begin
      rdy  = (sweep_left == 0);
      rdat = (w && wa == ra) ? wd : m_mem[ra];
      if (rdy && w) m_mem[wa] = wd;
      if (sweep_left > 0) sweep_left--;
      for (int i = LAT - 1; i > 0; i--) begin pv[i] = pv[i-1]; pd[i] = pd[i-1]; end
      pv[0] = rdy && r;
      pd[0] = rdat;
      if (pv[LAT-1]) exp_val = pd[LAT-1];
    end
    exp_valid = pv[LAT-1];
    exp_busy  = (sweep_left > 0);
    @(negedge clock);
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 2'd0, 8'h00, 1'b0, 2'd0);
  endtask

  task automatic test_reset();
    int cnt;
    cyc(1'b1, 1'b0, 2'd0, 8'h00, 1'b0, 2'd0);
    n_cmp++;
    if (busy !== 1'b1 || valid_out !== 1'b0 || value_out !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_state: busy=%b valid=%b value=%h, want busy=1 valid=0 value=00",
               busy, valid_out, value_out);
    end
    cnt = (busy === 1'b1) ? 1 : 0;
    for (int k = 0; k < 10 && busy === 1'b1; k++) begin
      idle();
      if (busy === 1'b1) cnt++;
    end
    n_cmp++;
    if (cnt != DEPTH || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL busy_len: got %0d cycles (busy now %b), want %0d then 0", cnt, busy, DEPTH);
    end
  endtask

  task automatic test_clear_sweep();
    int beats = 0;
    for (int a = 0; a < DEPTH + LAT; a++) begin
      if (a < DEPTH) cyc(1'b0, 1'b0, 2'd0, 8'h00, 1'b1, 2'(a));
      else idle();
      if (valid_out === 1'b1) beats++;
      n_cmp++;
      if (valid_out !== exp_valid || value_out !== exp_val || (exp_valid && value_out !== 8'h00)) begin
        n_fail++;
        $display("FAIL clear_read[%0d]: valid=%b value=%h, want valid=%b value=00", a, valid_out, value_out, exp_valid);
      end
    end
    n_cmp++;
    if (beats != DEPTH) begin
      n_fail++;
      $display("FAIL clear_beats: got %0d, want %0d", beats, DEPTH);
    end
  endtask

  task automatic test_write_read();
    cyc(1'b0, 1'b1, 2'd2, 8'hA5, 1'b0, 2'd0);
    cyc(1'b0, 1'b0, 2'd0, 8'h00, 1'b1, 2'd2);
    for (int k = 1; k < LAT; k++) idle();
    n_cmp++;
    if (valid_out !== 1'b1 || value_out !== 8'hA5) begin
      n_fail++;
      $display("FAIL write_read: valid=%b value=%h, want valid=1 value=a5", valid_out, value_out);
    end
    idle();
    n_cmp++;
    if (valid_out !== 1'b0 || value_out !== 8'hA5) begin
      n_fail++;
      $display("FAIL read_hold: valid=%b value=%h, want valid=0 value=a5", valid_out, value_out);
    end
  endtask

  task automatic test_bypass();
    cyc(1'b0, 1'b1, 2'd1, 8'h3C, 1'b1, 2'd1);
    for (int k = 1; k < LAT; k++) idle();
    n_cmp++;
    if (valid_out !== 1'b1 || value_out !== 8'h3C) begin
      n_fail++;
      $display("FAIL bypass: valid=%b value=%h, want valid=1 value=3c", valid_out, value_out);
    end
    // Different addresses: old contents of @2 (a5) come back.
    cyc(1'b0, 1'b1, 2'd3, 8'h77, 1'b1, 2'd2);
    for (int k = 1; k < LAT; k++) idle();
    n_cmp++;
    if (valid_out !== 1'b1 || value_out !== 8'hA5) begin
      n_fail++;
      $display("FAIL rdw_diff_addr: valid=%b value=%h, want valid=1 value=a5", valid_out, value_out);
    end
  endtask

  task automatic test_busy_lockout();
    cyc(1'b1, 1'b0, 2'd0, 8'h00, 1'b0, 2'd0);
    cyc(1'b0, 1'b1, 2'd0, 8'hFF, 1'b1, 2'd0);
    for (int k = 0; k < DEPTH + LAT; k++) begin
      n_cmp++;
      if (valid_out !== 1'b0 || busy !== exp_busy) begin
        n_fail++;
        $display("FAIL lockout[%0d]: valid=%b busy=%b, want valid=0 busy=%b", k, valid_out, busy, exp_busy);
      end
      idle();
    end
    cyc(1'b0, 1'b0, 2'd0, 8'h00, 1'b1, 2'd0);
    for (int k = 1; k < LAT; k++) idle();
    n_cmp++;
    if (valid_out !== 1'b1 || value_out !== 8'h00) begin
      n_fail++;
      $display("FAIL lockout_read0: valid=%b value=%h, want valid=1 value=00", valid_out, value_out);
    end
  endtask

  task automatic test_reset_midop();
    int cnt = 0;
    for (int a = 0; a < DEPTH; a++) cyc(1'b0, 1'b1, 2'(a), 8'(8'h11 * (a + 1)), 1'b0, 2'd0);
    cyc(1'b0, 1'b0, 2'd0, 8'h00, 1'b1, 2'd3);
    cyc(1'b1, 1'b0, 2'd0, 8'h00, 1'b0, 2'd0);
    n_cmp++;
    if (valid_out !== 1'b0 || busy !== 1'b1 || value_out !== 8'h00) begin
      n_fail++;
      $display("FAIL midop_reset: valid=%b busy=%b value=%h, want 0/1/00", valid_out, busy, value_out);
    end
    for (int k = 0; k < DEPTH + 2; k++) begin
      if (busy === 1'b1) cnt++;
      if (valid_out === 1'b1) cnt += 100;
      idle();
    end
    n_cmp++;
    if (cnt != DEPTH) begin
      n_fail++;
      $display("FAIL midop_busy: got code %0d, want %0d busy cycles and no valid", cnt, DEPTH);
    end
    for (int a = 0; a < DEPTH + LAT; a++) begin
      if (a < DEPTH) cyc(1'b0, 1'b0, 2'd0, 8'h00, 1'b1, 2'(a));
      else idle();
      n_cmp++;
      if (valid_out !== exp_valid || value_out !== exp_val || (exp_valid && value_out !== 8'h00)) begin
        n_fail++;
        $display("FAIL midop_read[%0d]: valid=%b value=%h, want valid=%b value=00", a, valid_out, value_out, exp_valid);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] wr [DEPTH];
    int beats = 0;
    for (int a = 0; a < DEPTH; a++) begin
      wr[a] = 8'($urandom);
      cyc(1'b0, 1'b1, 2'(a), wr[a], 1'b0, 2'd0);
    end
    for (int k = 0; k < DEPTH + LAT; k++) begin
      if (k < DEPTH) cyc(1'b0, 1'b0, 2'd0, 8'h00, 1'b1, 2'(k));
      else idle();
      if (k >= LAT - 1 && k < DEPTH + LAT - 1) begin
        n_cmp++;
        if (valid_out !== 1'b1 || value_out !== wr[beats]) begin
          n_fail++;
          $display("FAIL stream[%0d]: valid=%b value=%h, want valid=1 value=%h", beats, valid_out, value_out, wr[beats]);
        end
        beats++;
      end
    end
    n_cmp++;
    if (valid_out !== 1'b0) begin
      n_fail++;
      $display("FAIL stream_end: valid=%b, want 0", valid_out);
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      cyc(($urandom_range(0, 59) == 0), 1'($urandom), 2'($urandom), 8'($urandom),
          1'($urandom), 2'($urandom));
      n_cmp++;
      if (valid_out !== exp_valid || value_out !== exp_val || busy !== exp_busy) begin
        n_fail++;
        $display("FAIL random[%0d]: valid=%b value=%h busy=%b, want valid=%b value=%h busy=%b",
                 k, valid_out, value_out, busy, exp_valid, exp_val, exp_busy);
      end
    end
  endtask

  initial begin
    reset = 1'b1; we = 1'b0; re = 1'b0;
    address_in = '0; address_out = '0; value_in = '0;
    for (int i = 0; i < DEPTH; i++) m_mem[i] = 8'h00;
    for (int i = 0; i < LAT; i++) begin pv[i] = 1'b0; pd[i] = 8'h00; end
    test_reset();
    test_clear_sweep();
    test_write_read();
    test_bypass();
    test_busy_lockout();
    test_reset_midop();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
